riscv_inst_unpack_pipe: RTL

Pipelined RISC-V instruction unpacker. It accepts packed 32-bit instruction messages over a val/rdy interface and classifies each one by format. It extracts the register and function fields and reassembles the sign-extended immediate. It sits between instruction fetch and the execute control logic, and performs the inverse of the field packing defined by the `RISCV_INST_MSG_*` layout.

---
 rtl/riscv_inst_unpack_pipe_if.sv | 43 ++++
 rtl/riscv_inst_unpack_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_inst_unpack_pipe_if.sv
// Val/rdy bus for the instruction unpacker: packed instruction in, decoded fields out.
interface riscv_inst_unpack_pipe_if;

  localparam int unsigned inst_w   = 32;
  localparam int unsigned opcode_w = 7;
  localparam int unsigned reg_w    = 5;
  localparam int unsigned funct3_w = 3;
  localparam int unsigned funct7_w = 7;
  localparam int unsigned fmt_w    = 3;

  // input channel
  logic [inst_w-1:0]   in_msg;
  logic                in_val;
  logic                in_rdy;

  // output channel
  logic                out_val;
  logic                out_rdy;
  logic [opcode_w-1:0] out_opcode;
  logic [reg_w-1:0]    out_rd;
  logic [funct3_w-1:0] out_funct3;
  logic [reg_w-1:0]    out_rs1;
  logic [reg_w-1:0]    out_rs2;
  logic [funct7_w-1:0] out_funct7;
  logic [fmt_w-1:0]    out_fmt;
  logic [inst_w-1:0]   out_imm;
  logic                out_illegal;

  // unpacker side
  modport slave (
    input  in_msg, in_val, out_rdy,
    output in_rdy, out_val, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
           out_funct7, out_fmt, out_imm, out_illegal
  );

  // producer/consumer side
  modport master (
    output in_msg, in_val, out_rdy,
    input  in_rdy, out_val, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
           out_funct7, out_fmt, out_imm, out_illegal
  );

endinterface

// File: rtl/riscv_inst_unpack_pipe.sv
// Pipelined RISC-V instruction unpacker: format classification, field extraction
// and immediate reassembly behind a two-entry (main + skid) output buffer.
module riscv_inst_unpack_pipe #(
  parameter int unsigned p_cnt_w = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  riscv_inst_unpack_pipe_if.slave     bus,
  output logic [p_cnt_w-1:0]          illegal_cnt
);

  localparam int unsigned inst_w = 32;
  localparam int unsigned fmt_w  = 3;

  localparam logic [fmt_w-1:0] fmt_r   = 3'd0;
  localparam logic [fmt_w-1:0] fmt_i   = 3'd1;
  localparam logic [fmt_w-1:0] fmt_s   = 3'd2;
  localparam logic [fmt_w-1:0] fmt_sb  = 3'd3;
  localparam logic [fmt_w-1:0] fmt_u   = 3'd4;
  localparam logic [fmt_w-1:0] fmt_uj  = 3'd5;
  localparam logic [fmt_w-1:0] fmt_ill = 3'd7;

  localparam logic [6:0] op_op     = 7'b0110011;
  localparam logic [6:0] op_op_imm = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;
  localparam logic [6:0] op_jal    = 7'b1101111;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [fmt_w-1:0]  fmt;
    logic [inst_w-1:0] imm;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    st_empty = 2'd0,
    st_one   = 2'd1,
    st_two   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  bundle_t           dec;
  bundle_t           m_reg;
  bundle_t           k_reg;
  logic              out_val_q;
  logic              in_rdy_q;
  logic              in_xfer;
  logic              out_xfer;
  logic              ld_m_in;
  logic              ld_m_k;
  logic              ld_k;
  logic [p_cnt_w-1:0] cnt_q;

  logic [inst_w-1:0] inst;
  logic [inst_w-1:0] imm_i;
  logic [inst_w-1:0] imm_s;
  logic [inst_w-1:0] imm_sb;
  logic [inst_w-1:0] imm_u;
  logic [inst_w-1:0] imm_uj;

  assign inst     = bus.in_msg;
  assign in_xfer  = bus.in_val & in_rdy_q;
  assign out_xfer = out_val_q & bus.out_rdy;

  // Candidate immediates for every format; sign always comes from inst[31]
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_sb = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_uj = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode the incoming instruction into a bundle; raw fields pass through unconditionally
  always_comb begin
    dec         = '0;
    dec.opcode  = inst[6:0];
    dec.rd      = inst[11:7];
    dec.funct3  = inst[14:12];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.funct7  = inst[31:25];
    dec.fmt     = fmt_ill;
    dec.imm     = '0;
    dec.illegal = 1'b0;
    case (inst[6:0])
      op_op: begin
        dec.fmt = fmt_r;
      end
      op_op_imm, op_load, op_jalr: begin
        dec.fmt = fmt_i;
        dec.imm = imm_i;
      end
      op_store: begin
        dec.fmt = fmt_s;
        dec.imm = imm_s;
      end
      op_branch: begin
        dec.fmt = fmt_sb;
        dec.imm = imm_sb;
      end
      op_lui, op_auipc: begin
        dec.fmt = fmt_u;
        dec.imm = imm_u;
      end
      op_jal: begin
        dec.fmt = fmt_uj;
        dec.imm = imm_uj;
      end
      default: begin
        dec.fmt     = fmt_ill;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Buffer occupancy: next state and which register loads this cycle
  always_comb begin
    next_state = state;
    ld_m_in    = 1'b0;
    ld_m_k     = 1'b0;
    ld_k       = 1'b0;
    case (state)
      st_empty: begin
        if (in_xfer) begin
          next_state = st_one;
          ld_m_in    = 1'b1;
        end
      end
      st_one: begin
        if (in_xfer && out_xfer) begin
          ld_m_in = 1'b1;
        end else if (in_xfer) begin
          next_state = st_two;
          ld_k       = 1'b1;
        end else if (out_xfer) begin
          next_state = st_empty;
        end
      end
      st_two: begin
        if (out_xfer) begin
          next_state = st_one;
          ld_m_k     = 1'b1;
        end
      end
      default: begin
        next_state = st_empty;
      end
    endcase
  end

  // State plus registered handshake outputs derived from the next occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= st_empty;
      out_val_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state     <= next_state;
      out_val_q <= (next_state != st_empty);
      in_rdy_q  <= (next_state != st_two);
    end
  end

  // Main output register: fresh bundle, or promotion from the skid register
  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg <= '0;
    end else if (ld_m_in) begin
      m_reg <= dec;
    end else if (ld_m_k) begin
      m_reg <= k_reg;
    end
  end

  // Skid register: catches the bundle accepted while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg <= '0;
    end else if (ld_k) begin
      k_reg <= dec;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (in_xfer && dec.illegal && (cnt_q != {p_cnt_w{1'b1}})) begin
      cnt_q <= cnt_q + p_cnt_w'(1);
    end
  end

  assign bus.in_rdy      = in_rdy_q;
  assign bus.out_val     = out_val_q;
  assign bus.out_opcode  = m_reg.opcode;
  assign bus.out_rd      = m_reg.rd;
  assign bus.out_funct3  = m_reg.funct3;
  assign bus.out_rs1     = m_reg.rs1;
  assign bus.out_rs2     = m_reg.rs2;
  assign bus.out_funct7  = m_reg.funct7;
  assign bus.out_fmt     = m_reg.fmt;
  assign bus.out_imm     = m_reg.imm;
  assign bus.out_illegal = m_reg.illegal;
  assign illegal_cnt     = cnt_q;

endmodule
